// File: rtl/com_pkg.sv
// Shared definitions for the HV/LV inter-die status link.
// Holds the status frame layout, the transmitter FSM encoding and the
// CRC-4 routine that both the HV transmitter and the LV receiver use,
// so the two sides cannot drift apart on polynomial or bit order.
package com_pkg;

   // CRC-4 with polynomial x^4 + x + 1 (the x^4 term is implicit).
   localparam logic [3:0] CRC4_POLY = 4'h3;
   localparam logic [3:0] CRC4_INIT = 4'hF;

   // Serial payload length in bits.
   localparam int FRM_BITS = 16;

   // Transmitter sequencing: idle line, start bit, payload, stop bit, gap.
   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
      ST_STOP,
      ST_GAP
   } hv_tx_state_e;

   // Payload layout, MSB first on the wire.
   typedef struct packed {
      logic [3:0] hv_state;
      logic [5:0] flt;
      logic [1:0] seq;
      logic [3:0] crc;
   } str_hv_frm;

   // CRC-4 over the 12 header bits, MSB first, no reflection, no final XOR.
   function automatic logic [3:0] crc4(input logic [11:0] data);
      logic [3:0] crc;
      logic       fb;
      crc = CRC4_INIT;
      for (int i = 11; i >= 0; i--) begin
         fb  = crc[3] ^ data[i];
         crc = {crc[2:0], 1'b0};
         if (fb) begin
            crc = crc ^ CRC4_POLY;
         end
      end
      return crc;
   endfunction

endpackage

// File: rtl/hv_stat_frm_tx_if.sv
// Bus bundle between the HV status frame transmitter and its surroundings.
// The slave side is the transmitter; the master side is whoever supplies
// the HV state/fault snapshot and watches the serial line.
interface hv_stat_frm_tx_if;
   import com_pkg::*;

   logic       tx_en_i;
   logic [3:0] hv_state_i;
   logic [5:0] hv_flt_i;
   logic [1:0] wdgrefresh_cfg_i;
   logic       tx_o;
   logic       busy_o;
   logic       frm_done_o;
   logic [1:0] seq_o;

   modport master (
      output tx_en_i,
      output hv_state_i,
      output hv_flt_i,
      output wdgrefresh_cfg_i,
      input  tx_o,
      input  busy_o,
      input  frm_done_o,
      input  seq_o
   );

   modport slave (
      input  tx_en_i,
      input  hv_state_i,
      input  hv_flt_i,
      input  wdgrefresh_cfg_i,
      output tx_o,
      output busy_o,
      output frm_done_o,
      output seq_o
   );

endinterface

// File: rtl/hv_stat_refresh_tmr.sv
// Refresh timer for the HV status transmitter.
// Counts clocks while transmission is enabled, decodes the selected refresh
// period (base << cfg), raises the frame trigger and remembers a trigger that
// arrives while the transmitter is still busy so it is not lost.
module hv_stat_refresh_tmr
#(
   parameter int REFRESH_BASE = 256
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       tx_en_i,
   input  logic [1:0] cfg_i,
   input  logic       evt_i,
   input  logic       accept_i,
   output logic       trig_o,
   output logic       pend_o
);
   import com_pkg::*;

   // Wide enough for the longest period (8x base) plus headroom.
   localparam int CNT_W = $clog2(REFRESH_BASE) + 4;

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;
   logic [CNT_W-1:0] cntInc;
   logic [CNT_W-1:0] period;
   logic             pend_q;
   logic             pend_d;
   logic             refreshHit;
   logic             evtHit;

   // Period decode and trigger generation. Comparing with >= (not ==) means a
   // switch to a shorter period that the counter has already passed fires on
   // the very next cycle instead of waiting for a counter wrap.
   always_comb begin
      period     = CNT_W'(REFRESH_BASE) << cfg_i;
      cntInc     = cnt_q + CNT_W'(1);
      refreshHit = tx_en_i && (cntInc >= period);
      evtHit     = tx_en_i && evt_i;
      trig_o     = refreshHit || evtHit;
   end

   // Next counter value: held at zero while disabled, restarted on a trigger.
   always_comb begin
      cnt_d = cntInc;
      if (!tx_en_i || trig_o) begin
         cnt_d = '0;
      end
   end

   // Pending flag: any number of triggers seen while busy collapse into one
   // request, dropped once the frame is accepted or transmission is disabled.
   always_comb begin
      pend_d = tx_en_i && !accept_i && (pend_q || trig_o);
   end

   // Counter and pending state registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q  <= '0;
         pend_q <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         pend_q <= pend_d;
      end
   end

   assign pend_o = pend_q;

endmodule

// File: rtl/hv_stat_frm_tx.sv
// HV-side status frame transmitter for the isolated inter-die link.
// Periodically snapshots HV driver state and the six fault flags, appends a
// 2-bit sequence number and a CRC-4, and sends an 18-bit NRZ frame
// (start 0, 16 payload bits MSB first, stop 1) followed by a 2-bit idle gap.
// Optional build macro HV_TX_EVT_TRIG_EN: any change of the state/fault inputs
// against the last transmitted snapshot also triggers a frame.
module hv_stat_frm_tx
#(
   parameter int BIT_CYC      = 4,
   parameter int REFRESH_BASE = 256
) (
   input logic             clk,
   input logic             rst,
   hv_stat_frm_tx_if.slave bus
);
   import com_pkg::*;

   localparam int                CYC_W    = $clog2(2 * BIT_CYC) + 1;
   localparam logic [CYC_W-1:0]  BIT_LAST = CYC_W'(BIT_CYC - 1);
   localparam logic [CYC_W-1:0]  GAP_LAST = CYC_W'(2 * BIT_CYC - 1);
   localparam logic [3:0]        LAST_BIT = 4'(FRM_BITS - 1);

   hv_tx_state_e        state_q;
   hv_tx_state_e        state_d;
   logic [CYC_W-1:0]    cycCnt_q;
   logic [CYC_W-1:0]    cycCnt_d;
   logic [3:0]          bitIdx_q;
   logic [3:0]          bitIdx_d;
   logic [FRM_BITS-1:0] shift_q;
   logic [FRM_BITS-1:0] shift_d;
   logic [1:0]          seqCnt_q;
   logic [1:0]          seqCnt_d;
   logic [1:0]          frmSeq_q;
   logic [1:0]          frmSeq_d;
   logic [1:0]          seqOut_q;
   logic [1:0]          seqOut_d;

   logic                trig;
   logic                pend;
   logic                evt;
   logic                frameSlot;
   logic                load;
   logic [3:0]          loadCrc;
   str_hv_frm           loadFrm;
   logic                txLine;

   hv_stat_refresh_tmr #(
      .REFRESH_BASE (REFRESH_BASE)
   ) u_refresh_tmr (
      .clk      (clk),
      .rst      (rst),
      .tx_en_i  (bus.tx_en_i),
      .cfg_i    (bus.wdgrefresh_cfg_i),
      .evt_i    (evt),
      .accept_i (load),
      .trig_o   (trig),
      .pend_o   (pend)
   );

`ifdef HV_TX_EVT_TRIG_EN
   logic [9:0] snap_q;

   // Remember what the LV side was last sent so a change can fire a frame early.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         snap_q <= '0;
      end else if (load) begin
         snap_q <= {bus.hv_state_i, bus.hv_flt_i};
      end
   end

   assign evt = (snap_q != {bus.hv_state_i, bus.hv_flt_i});
`else
   assign evt = 1'b0;
`endif

   // A new frame may start from IDLE or straight out of the final gap cycle,
   // so a pending request follows the previous gap with no extra idle cycle.
   always_comb begin
      frameSlot = (state_q == ST_IDLE) ||
                  ((state_q == ST_GAP) && (cycCnt_q == GAP_LAST));
      load      = frameSlot && bus.tx_en_i && (trig || pend);
   end

   // Assemble the frame from the live inputs; it is only captured on load,
   // so later input changes cannot disturb a frame already on the wire.
   always_comb begin
      loadCrc          = crc4({bus.hv_state_i, bus.hv_flt_i, seqCnt_q});
      loadFrm.hv_state = bus.hv_state_i;
      loadFrm.flt      = bus.hv_flt_i;
      loadFrm.seq      = seqCnt_q;
      loadFrm.crc      = loadCrc;
   end

   // Next-state logic: walks START -> DATA -> STOP -> GAP, one bit every
   // BIT_CYC clocks, and captures a new frame whenever load fires.
   always_comb begin
      state_d  = state_q;
      cycCnt_d = cycCnt_q;
      bitIdx_d = bitIdx_q;
      shift_d  = shift_q;
      seqCnt_d = seqCnt_q;
      frmSeq_d = frmSeq_q;
      seqOut_d = seqOut_q;

      case (state_q)
         ST_IDLE: begin
            if (load) begin
               state_d  = ST_START;
               cycCnt_d = '0;
            end
         end

         ST_START: begin
            if (cycCnt_q == BIT_LAST) begin
               state_d  = ST_DATA;
               cycCnt_d = '0;
               bitIdx_d = '0;
            end else begin
               cycCnt_d = cycCnt_q + CYC_W'(1);
            end
         end

         ST_DATA: begin
            if (cycCnt_q == BIT_LAST) begin
               cycCnt_d = '0;
               if (bitIdx_q == LAST_BIT) begin
                  state_d = ST_STOP;
               end else begin
                  bitIdx_d = bitIdx_q + 4'd1;
                  shift_d  = {shift_q[FRM_BITS-2:0], 1'b0};
               end
            end else begin
               cycCnt_d = cycCnt_q + CYC_W'(1);
            end
         end

         ST_STOP: begin
            if (cycCnt_q == BIT_LAST) begin
               state_d  = ST_GAP;
               cycCnt_d = '0;
               seqOut_d = frmSeq_q;
            end else begin
               cycCnt_d = cycCnt_q + CYC_W'(1);
            end
         end

         ST_GAP: begin
            if (cycCnt_q == GAP_LAST) begin
               cycCnt_d = '0;
               state_d  = load ? ST_START : ST_IDLE;
            end else begin
               cycCnt_d = cycCnt_q + CYC_W'(1);
            end
         end

         default: begin
            state_d  = ST_IDLE;
            cycCnt_d = '0;
         end
      endcase

      if (load) begin
         shift_d  = loadFrm;
         frmSeq_d = seqCnt_q;
         seqCnt_d = seqCnt_q + 2'd1;
      end
   end

   // State and datapath registers; reset drops the line back to idle at once.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         cycCnt_q <= '0;
         bitIdx_q <= '0;
         shift_q  <= '0;
         seqCnt_q <= '0;
         frmSeq_q <= '0;
         seqOut_q <= '0;
      end else begin
         state_q  <= state_d;
         cycCnt_q <= cycCnt_d;
         bitIdx_q <= bitIdx_d;
         shift_q  <= shift_d;
         seqCnt_q <= seqCnt_d;
         frmSeq_q <= frmSeq_d;
         seqOut_q <= seqOut_d;
      end
   end

   // Serial line driver: low for the start bit, payload MSB during data,
   // high everywhere else (stop, gap, idle).
   always_comb begin
      case (state_q)
         ST_START: txLine = 1'b0;
         ST_DATA:  txLine = shift_q[FRM_BITS-1];
         default:  txLine = 1'b1;
      endcase
   end

   assign bus.tx_o       = txLine;
   assign bus.busy_o     = (state_q != ST_IDLE);
   assign bus.frm_done_o = (state_q == ST_STOP) && (cycCnt_q == BIT_LAST);
   assign bus.seq_o      = seqOut_q;

endmodule

// File: tb/tb_hv_stat_frm_tx.sv
// Directed testbench for hv_stat_frm_tx with BIT_CYC=4, REFRESH_BASE=256.
// Frames are captured by sampling tx_o in the middle of every bit; expected
// payloads are hand-computed CRC-4 results.
module tb_hv_stat_frm_tx;

   localparam int BC = 4;
   localparam int RB = 256;

   logic clk;
   logic rst;
   int   cycle = 0;
   int   assertCount = 0;
   int   failCount = 0;

   hv_stat_frm_tx_if bus ();

   hv_stat_frm_tx #(
      .BIT_CYC      (BC),
      .REFRESH_BASE (RB)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // Free-running clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Cycle stamp used to measure frame spacing
   always @(posedge clk) cycle <= cycle + 1;

   // Global safety net so the run always ends
   initial begin
      #600000;
      $display("[TB] FAIL watchdog: simulation time got exhausted, expected finish earlier");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic applyReset(input logic [3:0] st, input logic [5:0] flt);
      rst                  = 1'b1;
      bus.tx_en_i          = 1'b1;
      bus.hv_state_i       = st;
      bus.hv_flt_i         = flt;
      bus.wdgrefresh_cfg_i = 2'd0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
   endtask

   // Waits for a start bit, then samples the 16 payload bits mid-bit and the
   // stop bit. Returns at the middle of the stop bit. An optional hook at a
   // given offset after the start changes tx_en_i and hv_flt_i.
   task automatic recvFrame(input int budget, input int hookAt, input logic hookTxEn,
                            input logic [5:0] hookFlt, output logic [15:0] payload,
                            output int startCyc, output bit ok);
      int waited;
      bit seen;
      payload  = '0;
      startCyc = 0;
      ok       = 1'b0;
      seen     = 1'b0;
      waited   = 0;
      while (!seen && waited < budget) begin
         @(negedge clk);
         waited++;
         if (bus.tx_o === 1'b0) seen = 1'b1;
      end
      if (seen) begin
         ok       = 1'b1;
         startCyc = cycle;
         for (int off = 1; off <= 17 * BC + BC / 2; off++) begin
            @(negedge clk);
            if (off == hookAt) begin
               bus.tx_en_i  = hookTxEn;
               bus.hv_flt_i = hookFlt;
            end
            if (off == BC / 2 && bus.tx_o !== 1'b0) ok = 1'b0;
            if (off >= BC + BC / 2 && off < 17 * BC && ((off - BC / 2) % BC) == 0)
               payload = {payload[14:0], bus.tx_o};
            if (off == 17 * BC + BC / 2 && bus.tx_o !== 1'b1) ok = 1'b0;
         end
      end
   endtask

   task automatic test_reset();
      rst                  = 1'b1;
      bus.tx_en_i          = 1'b0;
      bus.hv_state_i       = 4'h0;
      bus.hv_flt_i         = 6'h00;
      bus.wdgrefresh_cfg_i = 2'd0;
      repeat (2) @(negedge clk);
      assertCount++;
      if (bus.tx_o !== 1'b1) begin
         failCount++; $display("[TB] FAIL reset_tx: got %b expected 1", bus.tx_o);
      end
      assertCount++;
      if (bus.busy_o !== 1'b0) begin
         failCount++; $display("[TB] FAIL reset_busy: got %b expected 0", bus.busy_o);
      end
      assertCount++;
      if (bus.frm_done_o !== 1'b0) begin
         failCount++; $display("[TB] FAIL reset_done: got %b expected 0", bus.frm_done_o);
      end
      assertCount++;
      if (bus.seq_o !== 2'd0) begin
         failCount++; $display("[TB] FAIL reset_seq: got %0d expected 0", bus.seq_o);
      end
   endtask

   task automatic test_first_frame();
      logic [15:0] pl;
      int          sc;
      bit          ok;
      bit          found;
      int          doneCyc;
      logic [1:0]  seqAtDone;
      applyReset(4'h0, 6'h00);
      recvFrame(400, -1, 1'b1, 6'h00, pl, sc, ok);
      assertCount++;
      if (!ok) begin
         failCount++; $display("[TB] FAIL first_frame_rx: got ok=%b expected ok=1", ok);
      end
      assertCount++;
      if (pl !== 16'h000A) begin
         failCount++; $display("[TB] FAIL first_frame_payload: got %h expected 000a", pl);
      end
      found     = 1'b0;
      doneCyc   = 0;
      seqAtDone = 2'bxx;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (bus.frm_done_o === 1'b1) begin
            found     = 1'b1;
            doneCyc   = cycle;
            seqAtDone = bus.seq_o;
            break;
         end
      end
      assertCount++;
      if (!found || (doneCyc - sc) != 18 * BC - 1) begin
         failCount++;
         $display("[TB] FAIL first_frame_done: got offset %0d expected %0d", doneCyc - sc, 18 * BC - 1);
      end
      assertCount++;
      if (seqAtDone !== 2'd0) begin
         failCount++; $display("[TB] FAIL first_frame_seq_o: got %0d expected 0", seqAtDone);
      end
   endtask

   task automatic test_refresh_periods();
      logic [15:0] pl;
      int          sA;
      int          sB;
      bit          okA;
      bit          okB;
      for (int c = 0; c < 4; c++) begin
         bus.wdgrefresh_cfg_i = 2'(c);
         recvFrame(2 * (RB << c) + 200, -1, 1'b1, 6'h00, pl, sA, okA);
         recvFrame(2 * (RB << c) + 200, -1, 1'b1, 6'h00, pl, sB, okB);
         assertCount++;
         if (!(okA && okB)) begin
            failCount++; $display("[TB] FAIL period_rx cfg%0d: got ok=%b%b expected 11", c, okA, okB);
         end
         assertCount++;
         if ((sB - sA) != (RB << c)) begin
            failCount++; $display("[TB] FAIL period cfg%0d: got %0d expected %0d", c, sB - sA, RB << c);
         end
      end
   endtask

   task automatic test_seq_wrap();
      logic [15:0] expPl [5];
      logic [15:0] pl;
      int          sc;
      bit          ok;
      expPl[0] = 16'h000A;
      expPl[1] = 16'h0019;
      expPl[2] = 16'h002C;
      expPl[3] = 16'h003F;
      expPl[4] = 16'h000A;
      applyReset(4'h0, 6'h00);
      for (int i = 0; i < 5; i++) begin
         recvFrame(400, -1, 1'b1, 6'h00, pl, sc, ok);
         assertCount++;
         if (!ok || pl !== expPl[i]) begin
            failCount++; $display("[TB] FAIL seq_frame%0d: got %h ok=%b expected %h", i, pl, ok, expPl[i]);
         end
         repeat (2) @(negedge clk);
         assertCount++;
         if (bus.seq_o !== 2'(i % 4)) begin
            failCount++; $display("[TB] FAIL seq_o%0d: got %0d expected %0d", i, bus.seq_o, i % 4);
         end
      end
   endtask

   task automatic test_reset_mid_frame();
      logic [15:0] pl;
      int          sc;
      bit          ok;
      bit          found;
      found = 1'b0;
      for (int w = 0; w < 400; w++) begin
         @(negedge clk);
         if (bus.tx_o === 1'b0) begin
            found = 1'b1;
            break;
         end
      end
      assertCount++;
      if (!found) begin
         failCount++; $display("[TB] FAIL midrst_start: got no start expected start bit");
      end
      repeat (8 * BC + 1) @(negedge clk);
      assertCount++;
      if (bus.busy_o !== 1'b1 || bus.tx_o !== 1'b0) begin
         failCount++; $display("[TB] FAIL midrst_bit7: got busy=%b tx=%b expected busy=1 tx=0", bus.busy_o, bus.tx_o);
      end
      rst = 1'b1;
      #1;
      assertCount++;
      if (bus.tx_o !== 1'b1) begin
         failCount++; $display("[TB] FAIL midrst_tx: got %b expected 1", bus.tx_o);
      end
      assertCount++;
      if (bus.busy_o !== 1'b0) begin
         failCount++; $display("[TB] FAIL midrst_busy: got %b expected 0", bus.busy_o);
      end
      assertCount++;
      if (bus.seq_o !== 2'd0 || bus.frm_done_o !== 1'b0) begin
         failCount++; $display("[TB] FAIL midrst_outs: got seq=%0d done=%b expected 0 0", bus.seq_o, bus.frm_done_o);
      end
      @(negedge clk);
      rst = 1'b0;
      recvFrame(400, -1, 1'b1, 6'h00, pl, sc, ok);
      assertCount++;
      if (!ok || pl !== 16'h000A) begin
         failCount++; $display("[TB] FAIL midrst_next: got %h ok=%b expected 000a", pl, ok);
      end
   endtask

   task automatic test_tx_en_drop();
      logic [15:0] pl;
      int          sc;
      bit          ok;
      int          lows;
      applyReset(4'h5, 6'b100001);
      recvFrame(400, 20, 1'b0, 6'b100001, pl, sc, ok);
      assertCount++;
      if (!ok) begin
         failCount++; $display("[TB] FAIL txen_rx: got ok=%b expected ok=1", ok);
      end
      assertCount++;
      if (pl !== 16'h584E) begin
         failCount++; $display("[TB] FAIL txen_payload: got %h expected 584e", pl);
      end
      lows = 0;
      repeat (4 * RB) begin
         @(negedge clk);
         if (bus.tx_o === 1'b0) lows++;
      end
      assertCount++;
      if (lows != 0) begin
         failCount++; $display("[TB] FAIL txen_quiet: got %0d low cycles expected 0", lows);
      end
      assertCount++;
      if (bus.busy_o !== 1'b0) begin
         failCount++; $display("[TB] FAIL txen_busy: got %b expected 0", bus.busy_o);
      end
   endtask

   task automatic test_event_trigger();
      logic [15:0] pl1;
      logic [15:0] pl2;
      int          s1;
      int          s2;
      bit          ok1;
      bit          ok2;
      int          expGap;
`ifdef HV_TX_EVT_TRIG_EN
      expGap = 20 * BC;
`else
      expGap = RB;
`endif
      applyReset(4'h0, 6'h00);
      recvFrame(400, 20, 1'b1, 6'b010000, pl1, s1, ok1);
      assertCount++;
      if (!ok1 || pl1 !== 16'h000A) begin
         failCount++; $display("[TB] FAIL evt_first: got %h ok=%b expected 000a", pl1, ok1);
      end
      recvFrame(600, -1, 1'b1, 6'b010000, pl2, s2, ok2);
      assertCount++;
      if (!ok2) begin
         failCount++; $display("[TB] FAIL evt_second_rx: got ok=%b expected ok=1", ok2);
      end
      assertCount++;
      if (pl2 !== 16'h041E) begin
         failCount++; $display("[TB] FAIL evt_second_payload: got %h expected 041e", pl2);
      end
      assertCount++;
      if ((s2 - s1) != expGap) begin
         failCount++; $display("[TB] FAIL evt_spacing: got %0d expected %0d", s2 - s1, expGap);
      end
   endtask

   // Test sequence
   initial begin
      rst                  = 1'b1;
      bus.tx_en_i          = 1'b0;
      bus.hv_state_i       = 4'h0;
      bus.hv_flt_i         = 6'h00;
      bus.wdgrefresh_cfg_i = 2'd0;
      $display("[TB] starting hv_stat_frm_tx bench");
      test_reset();
      test_first_frame();
      test_refresh_periods();
      test_seq_wrap();
      test_reset_mid_frame();
      test_tx_en_drop();
      test_event_trigger();
      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule
